// File: rtl/sort_pkg.sv
// Shared types for the systolic insertion sorter: FSM states and the
// key/tag record that moves between cells.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  // Records are sized for the widest supported key/tag; narrower
  // configurations leave the upper bits at zero.
  localparam int KEY_W_MAX = 32;
  localparam int TAG_W_MAX = 32;

  typedef struct packed {
    logic [KEY_W_MAX-1:0] key;
    logic [TAG_W_MAX-1:0] tag;
  } elem_t;

endpackage

// File: rtl/sort_cell.sv
// One storage slot of the sorter: holds an element, decides whether the
// incoming key belongs after it, and muxes between hold, insert and shift.
module sort_cell
  import sort_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  insert_i,
  input  logic  shift_i,
  input  logic  descending_i,
  input  logic  placeHere_i,
  input  elem_t newElem_i,
  input  elem_t prevElem_i,
  input  logic  prevValid_i,
  input  elem_t nextElem_i,
  input  logic  nextValid_i,
  output elem_t elem_o,
  output logic  valid_o,
  output logic  goesAfter_o
);

  elem_t elem_q, elem_d;
  logic  valid_q, valid_d;

  // Equal keys count as "goes after" so later arrivals stay behind earlier ones.
  always_comb begin
    goesAfter_o = valid_q && (descending_i ? (elem_q.key >= newElem_i.key)
                                           : (elem_q.key <= newElem_i.key));
    elem_d  = elem_q;
    valid_d = valid_q;
    if (insert_i && !goesAfter_o) begin
      if (placeHere_i) begin
        elem_d  = newElem_i;
        valid_d = 1'b1;
      end else begin
        elem_d  = prevElem_i;
        valid_d = prevValid_i;
      end
    end else if (shift_i) begin
      elem_d  = nextElem_i;
      valid_d = nextValid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    elem_q <= elem_d;
  end

  assign elem_o  = elem_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/systolic_sort_stream.sv
// Streaming frame sorter: elements are insertion-sorted into a chain of
// cells as they arrive, then drained from cell 0 once the frame ends.
module systolic_sort_stream
  import sort_pkg::*;
#(
  parameter int SIZE      = 1024,
  parameter int WIDTH     = 12,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 descending,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_key,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_key,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             desc_q, desc_d;

  elem_t            newElem;
  elem_t            cellElem [SIZE];
  logic [SIZE-1:0]  cellValid;
  logic [SIZE-1:0]  cellAfter;
  logic             inFire, outFire, sortDesc, frameEnd;
  logic             unusedTail;

  assign in_ready  = !rst && (state_q != DRAIN);
  assign out_valid = !rst && (state_q == DRAIN);
  assign busy      = !rst && (state_q != IDLE);
  assign inFire    = in_valid && in_ready;
  assign outFire   = out_valid && out_ready;
  assign frameEnd  = in_last || (count_q == LAST_SLOT);
  assign overflow  = inFire && !in_last && (count_q == LAST_SLOT);
  assign out_key   = out_valid ? cellElem[0].key[WIDTH-1:0] : '0;
  assign out_tag   = out_valid ? cellElem[0].tag[TAG_WIDTH-1:0] : '0;
  assign out_last  = out_valid && (count_q == ONE);
  // The frame's first element is compared under the live order input.
  assign sortDesc  = (state_q == IDLE) ? descending : desc_q;
  assign unusedTail = cellAfter[SIZE-1];

  always_comb begin
    newElem = '0;
    newElem.key[WIDTH-1:0]     = in_key;
    newElem.tag[TAG_WIDTH-1:0] = in_tag;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    desc_d  = desc_q;
    case (state_q)
      IDLE: if (inFire) begin
        desc_d  = descending;
        count_d = count_q + ONE;
        state_d = frameEnd ? DRAIN : LOAD;
      end
      LOAD: if (inFire) begin
        count_d = count_q + ONE;
        if (frameEnd) state_d = DRAIN;
      end
      DRAIN: if (outFire) begin
        count_d = count_q - ONE;
        if (count_q == ONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      desc_q  <= desc_d;
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : gCell
    logic  placeHere, prevValid, nextValid;
    elem_t prevElem, nextElem;

    if (i == 0) begin : gHead
      assign placeHere = 1'b1;
      assign prevElem  = newElem;
      assign prevValid = 1'b0;
    end else begin : gBody
      assign placeHere = cellAfter[i-1];
      assign prevElem  = cellElem[i-1];
      assign prevValid = cellValid[i-1];
    end

    if (i == SIZE - 1) begin : gTail
      assign nextElem  = cellElem[i];
      assign nextValid = 1'b0;
    end else begin : gMid
      assign nextElem  = cellElem[i+1];
      assign nextValid = cellValid[i+1];
    end

    sort_cell uCell (
      .clk          (clk),
      .rst          (rst),
      .insert_i     (inFire),
      .shift_i      (outFire),
      .descending_i (sortDesc),
      .placeHere_i  (placeHere),
      .newElem_i    (newElem),
      .prevElem_i   (prevElem),
      .prevValid_i  (prevValid),
      .nextElem_i   (nextElem),
      .nextValid_i  (nextValid),
      .elem_o       (cellElem[i]),
      .valid_o      (cellValid[i]),
      .goesAfter_o  (cellAfter[i])
    );
  end

endmodule

// File: tb/tb_systolic_sort_stream.sv
// Directed bench for systolic_sort_stream: an 8-deep and a 4-deep instance
// share stimulus, with sel choosing which one is driven and observed.
module tb_systolic_sort_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, descending, inValid, inLast, outReady, sel, ovf;
  logic [11:0] inKey;
  logic [7:0]  inTag;

  logic        ir8, ov8, ol8, busy8, ovf8, ir4, ov4, ol4, busy4, ovf4;
  logic [11:0] ok8, ok4;
  logic [7:0]  ot8, ot4;
  logic        inValid8, inValid4;

  logic        inReady, outValid, outLast, busy, overflow;
  logic [11:0] outKey;
  logic [7:0]  outTag;

  logic [11:0] expKey [0:7];
  logic [7:0]  expTag [0:7];
  int          checkCount = 0;
  int          passCount  = 0;

  assign inValid8 = inValid & ~sel;
  assign inValid4 = inValid & sel;
  assign inReady  = sel ? ir4 : ir8;
  assign outValid = sel ? ov4 : ov8;
  assign outLast  = sel ? ol4 : ol8;
  assign busy     = sel ? busy4 : busy8;
  assign overflow = sel ? ovf4 : ovf8;
  assign outKey   = sel ? ok4 : ok8;
  assign outTag   = sel ? ot4 : ot8;

  systolic_sort_stream #(.SIZE(8), .WIDTH(12), .TAG_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .descending(descending),
    .in_valid(inValid8), .in_ready(ir8), .in_key(inKey), .in_tag(inTag), .in_last(inLast),
    .out_valid(ov8), .out_ready(outReady), .out_key(ok8), .out_tag(ot8), .out_last(ol8),
    .busy(busy8), .overflow(ovf8)
  );

  systolic_sort_stream #(.SIZE(4), .WIDTH(12), .TAG_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .descending(descending),
    .in_valid(inValid4), .in_ready(ir4), .in_key(inKey), .in_tag(inTag), .in_last(inLast),
    .out_valid(ov4), .out_ready(outReady), .out_key(ok4), .out_tag(ot4), .out_last(ol4),
    .busy(busy4), .overflow(ovf4)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Present one element at a falling edge and let the next rising edge take it.
  task automatic applyStimulus(input logic [11:0] k, input logic [7:0] t, input logic l,
                               output logic ovfSeen);
    inValid = 1'b1;
    inKey   = k;
    inTag   = t;
    inLast  = l;
    #1;
    checkOutput("inReady", 32'(inReady), 32'd1);
    ovfSeen = overflow;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  // Drain n elements against expKey/expTag, applying readyMask bit per cycle.
  task automatic drainFrame(input int n, input logic [31:0] readyMask);
    int idx, cyc;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 32) begin
      outReady = readyMask[cyc];
      #1;
      checkOutput("outValid", 32'(outValid), 32'd1);
      checkOutput("outKey", 32'(outKey), 32'(expKey[idx]));
      checkOutput("outTag", 32'(outTag), 32'(expTag[idx]));
      checkOutput("outLast", 32'(outLast), 32'(idx == n - 1));
      checkOutput("drainInReady", 32'(inReady), 32'd0);
      @(posedge clk);
      if (outReady) idx++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("drainCount", 32'(idx), 32'(n));
    outReady = 1'b1;
    #1;
    checkOutput("idleValid", 32'(outValid), 32'd0);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    checkOutput("idleReady", 32'(inReady), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] bench did not complete");
  end

  initial begin
    sel = 1'b0; rst = 1'b1; descending = 1'b0; inValid = 1'b0; inLast = 1'b0;
    inKey = '0; inTag = '0; outReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstValid", 32'(outValid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstReady", 32'(inReady), 32'd0);
    checkOutput("rstKey", 32'(outKey), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("postRstReady", 32'(inReady), 32'd1);

    // Ascending frame 5,3,9,1 on the 8-deep instance.
    applyStimulus(12'd5, 8'h10, 1'b0, ovf);
    applyStimulus(12'd3, 8'h11, 1'b0, ovf);
    applyStimulus(12'd9, 8'h12, 1'b0, ovf);
    #1;
    checkOutput("loadBusy", 32'(busy), 32'd1);
    checkOutput("loadNoOut", 32'(outValid), 32'd0);
    applyStimulus(12'd1, 8'h13, 1'b1, ovf);
    #1;
    checkOutput("latency", 32'(outValid), 32'd1);
    expKey[0] = 12'd1; expTag[0] = 8'h13;
    expKey[1] = 12'd3; expTag[1] = 8'h11;
    expKey[2] = 12'd5; expTag[2] = 8'h10;
    expKey[3] = 12'd9; expTag[3] = 8'h12;
    drainFrame(4, 32'hFFFF_FFFF);

    // Descending with duplicates; order input changes after the first element.
    descending = 1'b1;
    applyStimulus(12'd7, 8'h0A, 1'b0, ovf);
    descending = 1'b0;
    applyStimulus(12'd7, 8'h0B, 1'b0, ovf);
    applyStimulus(12'd2, 8'h02, 1'b0, ovf);
    applyStimulus(12'd7, 8'h0C, 1'b1, ovf);
    expKey[0] = 12'd7; expTag[0] = 8'h0A;
    expKey[1] = 12'd7; expTag[1] = 8'h0B;
    expKey[2] = 12'd7; expTag[2] = 8'h0C;
    expKey[3] = 12'd2; expTag[3] = 8'h02;
    drainFrame(4, 32'hFFFF_FFFF);

    // Overflow on the 4-deep instance; the fifth input waits through the drain.
    sel = 1'b1;
    #1;
    applyStimulus(12'd8, 8'h20, 1'b0, ovf);
    checkOutput("ovf1", 32'(ovf), 32'd0);
    applyStimulus(12'd2, 8'h21, 1'b0, ovf);
    checkOutput("ovf2", 32'(ovf), 32'd0);
    applyStimulus(12'd6, 8'h22, 1'b0, ovf);
    checkOutput("ovf3", 32'(ovf), 32'd0);
    applyStimulus(12'd4, 8'h23, 1'b0, ovf);
    checkOutput("ovf4", 32'(ovf), 32'd1);
    inValid = 1'b1; inKey = 12'd1; inTag = 8'h24; inLast = 1'b0;
    #1;
    checkOutput("ovfPulseEnd", 32'(overflow), 32'd0);
    checkOutput("ovfStall", 32'(inReady), 32'd0);
    expKey[0] = 12'd2; expTag[0] = 8'h21;
    expKey[1] = 12'd4; expTag[1] = 8'h23;
    expKey[2] = 12'd6; expTag[2] = 8'h22;
    expKey[3] = 12'd8; expTag[3] = 8'h20;
    drainFrame(4, 32'hFFFF_FFFF);
    applyStimulus(12'd1, 8'h24, 1'b0, ovf);
    applyStimulus(12'd3, 8'h25, 1'b1, ovf);
    expKey[0] = 12'd1; expTag[0] = 8'h24;
    expKey[1] = 12'd3; expTag[1] = 8'h25;
    drainFrame(2, 32'hFFFF_FFFF);
    sel = 1'b0;
    #1;

    // Back-pressure pattern 1,0,0,1,1 during drain.
    applyStimulus(12'd6, 8'h30, 1'b0, ovf);
    applyStimulus(12'd2, 8'h31, 1'b0, ovf);
    applyStimulus(12'd4, 8'h32, 1'b1, ovf);
    expKey[0] = 12'd2; expTag[0] = 8'h31;
    expKey[1] = 12'd4; expTag[1] = 8'h32;
    expKey[2] = 12'd6; expTag[2] = 8'h30;
    drainFrame(3, 32'hFFFF_FFF9);

    // Reset on the third drain cycle discards the rest of the frame.
    applyStimulus(12'd3, 8'h50, 1'b0, ovf);
    applyStimulus(12'd1, 8'h51, 1'b0, ovf);
    applyStimulus(12'd2, 8'h52, 1'b0, ovf);
    applyStimulus(12'd0, 8'h53, 1'b1, ovf);
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("preRstKey", 32'(outKey), 32'(i));
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("midRstValid", 32'(outValid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstReady", 32'(inReady), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("noPartial", 32'(outValid), 32'd0);
    checkOutput("relBusy", 32'(busy), 32'd0);
    applyStimulus(12'd4, 8'h40, 1'b0, ovf);
    applyStimulus(12'd0, 8'h41, 1'b1, ovf);
    expKey[0] = 12'd0; expTag[0] = 8'h41;
    expKey[1] = 12'd4; expTag[1] = 8'h40;
    drainFrame(2, 32'hFFFF_FFFF);

    // Single-element frame at the largest key.
    applyStimulus(12'd4095, 8'h55, 1'b1, ovf);
    expKey[0] = 12'd4095; expTag[0] = 8'h55;
    drainFrame(1, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/systolic_sort_stream.md
SYSTOLIC_SORT_STREAM -- requirements
Module: systolic_sort_stream

Interface
REQ-001 Parameter SIZE, default 1024, maximum elements per frame (>=2).
REQ-002 Parameter WIDTH, default 12, key width in bits.
REQ-003 Parameter TAG_WIDTH, default 8, payload width carried with each key.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 descending  input  1  sort order, 0 = ascending, 1 = descending.
REQ-007 in_valid / in_ready  input / output  1 / 1  input handshake.
REQ-008 in_key / in_tag / in_last  input  WIDTH / TAG_WIDTH / 1  element key, payload, end-of-frame marker.
REQ-009 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-010 out_key / out_tag / out_last  output  WIDTH / TAG_WIDTH / 1  sorted element and final-element marker.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 overflow  output  1  one-cycle pulse on forced frame termination.

Function
REQ-013 The block SHALL implement states IDLE, LOAD and DRAIN.
REQ-014 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL be 1 in IDLE and LOAD and 0 in DRAIN and while rst is high.
REQ-016 The first transfer in IDLE SHALL latch descending for the whole frame and move to LOAD; descending is ignored at all other times.
REQ-017 Each transfer SHALL insert the element in one cycle, keeping the occupied cells ordered: ascending places it after every cell with key <= in_key; descending places it after every cell with key >= in_key.
REQ-018 Equal keys SHALL leave in arrival order (stable sort); tags SHALL travel with their keys unchanged.
REQ-019 Keys SHALL be compared as unsigned WIDTH-bit values.
REQ-020 A transfer with in_last = 1 SHALL move the state to DRAIN; out_valid SHALL rise on the next cycle, giving a latency of 1 cycle from the last input to the first output.
REQ-021 If the SIZE-th element is accepted with in_last = 0, the block SHALL treat it as last, pulse overflow for one cycle and enter DRAIN; later inputs wait for in_ready.
REQ-022 A frame of one element SHALL be legal; the output is that element with out_last = 1.
REQ-023 In DRAIN, out_valid SHALL be 1, and out_key and out_tag SHALL present cell 0.
REQ-024 Each output transfer (out_valid and out_ready both 1) SHALL shift the cells one place toward cell 0 and decrement the occupancy count.
REQ-025 While out_ready is 0, all outputs SHALL hold stable.
REQ-026 out_last SHALL be 1 exactly when the occupancy count equals 1.
REQ-027 The transfer carrying out_last SHALL return the state to IDLE with out_valid = 0; in_ready = 1 from the following cycle.
REQ-028 The occupancy count SHALL be $clog2(SIZE+1) bits wide and SHALL never wrap.

Reset
REQ-029 While rst is high on a clock edge, the block SHALL reset the state to IDLE, the count to 0 and all cell-valid flags to 0.
REQ-030 While rst is high on a clock edge, the block SHALL drive out_valid, out_key, out_tag, out_last, busy and overflow to 0.
REQ-031 Asserting rst mid-LOAD or mid-DRAIN SHALL discard the frame; no partial output SHALL follow the reset.
REQ-032 Cell key and tag registers SHALL NOT need reset values.

Structure
REQ-033 A shared package sort_pkg SHALL hold the state enumeration (IDLE, LOAD, DRAIN) and the element record type (key, tag).
REQ-034 Each storage slot SHALL be one sub-module instance, sort_cell, containing the valid flag, key, tag, compare result, and insert/shift multiplexing.
REQ-035 The top level SHALL contain only the FSM, the occupancy counter and the generate loop of SIZE sort_cell instances.

Verification
REQ-036 Test: SIZE=8, ascending, keys 5,3,9,1 (last on 1) -> outputs 1,3,5,9; out_last on 9; first out_valid 1 cycle after the last input.
REQ-037 Test: descending, keys 7(tag A),7(tag B),2,7(tag C) -> outputs 7A,7B,7C,2, showing stable order.
REQ-038 Test: SIZE=4, six inputs, no in_last -> overflow pulses on the 4th input; output is the first four elements sorted; in_ready is 0 until drain completes.
REQ-039 Test: out_ready toggled 1,0,0,1 during drain -> outputs held stable while out_ready is 0; no element lost or duplicated.
REQ-040 Test: rst asserted on the 3rd drain cycle -> next cycle out_valid=0, busy=0, in_ready=0; after release a new 2-element frame {4,0} sorts to 0,4.
REQ-041 Test: single element 4095, with WIDTH=12 -> one output 4095 with out_last=1; the state returns to IDLE.
